dm_access_unit: RTL and testbench

Data-memory access unit for the MEM stage of the pipelined RV32I core. It consumes the decoder's memory controls (`mem_read`, `MemWrite`, `DMType`) plus the EX/MEM address and store data. It runs a req/ack transaction on the data bus, aligns store lanes and sign/zero-extends load data, and stalls the pipeline until the access completes or faults.

---
 rtl/dm_pkg.sv | 31 +++
 rtl/dm_lane_align.sv | 44 ++++
 rtl/dm_access_unit.sv | 134 +++++++++++++
 tb/tb_dm_access_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared data-memory encodings (also used by the decoder's DMType) and the
// access-unit FSM state type.
package dm_pkg;

   typedef enum logic [2:0] {
      DM_WORD   = 3'b000,
      DM_HALF   = 3'b001,
      DM_HALF_U = 3'b010,
      DM_BYTE   = 3'b011,
      DM_BYTE_U = 3'b100
   } dm_type_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } dm_state_e;

   // Codes 101-111 fall into the word case here.
   function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] lo);
      logic mis;
      mis = 1'b0;
      case (t)
         DM_HALF, DM_HALF_U: mis = lo[0];
         DM_BYTE, DM_BYTE_U: mis = 1'b0;
         default:            mis = (lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane logic: store replication / byte enables and load lane
// select with sign or zero extension.
module dm_lane_align
   import dm_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  dm_type,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_word,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   assign half_sel = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
   assign byte_sel = rdata_word[{addr_lo, 3'b000} +: 8];

   // Lane choice ignores the low address bits that would make an access
   // misaligned, so forced-alignment needs no extra logic.
   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata;
      rdata_ext = rdata_word;
      case (dm_type)
         DM_HALF, DM_HALF_U: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {wdata[15:0], wdata[15:0]};
            rdata_ext = (dm_type == DM_HALF) ? {{16{half_sel[15]}}, half_sel}
                                             : {16'h0000, half_sel};
         end
         DM_BYTE, DM_BYTE_U: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = (dm_type == DM_BYTE) ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'h000000, byte_sel};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dm_access_unit.sv
// MEM-stage data-memory access unit: req/ack bus transaction with stall.
// Optional DM_MISALIGN_TRAP_EN: misaligned accesses fault without bus activity.
module dm_access_unit
   import dm_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  dm_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   dm_state_e   state_reg;
   logic [2:0]  type_reg;
   logic [1:0]  addr_lo_reg;
   logic [CW-1:0] cnt_reg;
   logic [31:0] rdata_reg;
   logic        fault_reg;
   logic        bus_req_reg;
   logic        bus_we_reg;
   logic [31:0] bus_addr_reg;
   logic [3:0]  bus_be_reg;
   logic [31:0] bus_wdata_reg;

   logic        start;
   logic [1:0]  al_lo;
   logic [2:0]  al_type;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;

   assign start = mem_read | mem_write;
   assign stall = ((state_reg == ST_IDLE) & start) | (state_reg == ST_REQ);

   // The single aligner serves the incoming request in IDLE and the latched
   // request while waiting for read data.
   assign al_lo   = (state_reg == ST_IDLE) ? addr[1:0] : addr_lo_reg;
   assign al_type = (state_reg == ST_IDLE) ? dm_type   : type_reg;

   dm_lane_align u_align (
      .addr_lo    (al_lo),
      .dm_type    (al_type),
      .wdata      (wdata),
      .rdata_word (bus_rdata),
      .be         (al_be),
      .wdata_rep  (al_wdata),
      .rdata_ext  (al_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         type_reg      <= 3'b000;
         addr_lo_reg   <= 2'b00;
         cnt_reg       <= '0;
         rdata_reg     <= 32'h0;
         fault_reg     <= 1'b0;
         bus_req_reg   <= 1'b0;
         bus_we_reg    <= 1'b0;
         bus_addr_reg  <= 32'h0;
         bus_be_reg    <= 4'b0000;
         bus_wdata_reg <= 32'h0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  type_reg    <= dm_type;
                  addr_lo_reg <= addr[1:0];
                  cnt_reg     <= '0;
`ifdef DM_MISALIGN_TRAP_EN
                  if (is_misaligned(dm_type, addr[1:0])) begin
                     state_reg <= ST_DONE;
                     fault_reg <= 1'b1;
                     rdata_reg <= 32'h0;
                  end else
`endif
                  begin
                     state_reg     <= ST_REQ;
                     bus_req_reg   <= 1'b1;
                     bus_we_reg    <= mem_write;
                     bus_addr_reg  <= {addr[31:2], 2'b00};
                     bus_be_reg    <= al_be;
                     bus_wdata_reg <= mem_write ? al_wdata : 32'h0;
                  end
               end
            end
            ST_REQ: begin
               if (bus_ack || (cnt_reg == CW'(TIMEOUT - 1))) begin
                  state_reg     <= ST_DONE;
                  rdata_reg     <= (bus_ack && !bus_we_reg) ? al_rdata : 32'h0;
                  fault_reg     <= !bus_ack;
                  bus_req_reg   <= 1'b0;
                  bus_we_reg    <= 1'b0;
                  bus_addr_reg  <= 32'h0;
                  bus_be_reg    <= 4'b0000;
                  bus_wdata_reg <= 32'h0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
               fault_reg <= 1'b0;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign rdata     = rdata_reg;
   assign fault     = fault_reg;
   assign bus_req   = bus_req_reg;
   assign bus_we    = bus_we_reg;
   assign bus_addr  = bus_addr_reg;
   assign bus_be    = bus_be_reg;
   assign bus_wdata = bus_wdata_reg;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit (TIMEOUT=4); honours DM_MISALIGN_TRAP_EN.
module tb_dm_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [2:0]  dm_type;
   logic [31:0] addr, wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        fault;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dm_access_unit #(.TIMEOUT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .dm_type   (dm_type),
      .addr      (addr),
      .wdata     (wdata),
      .stall     (stall),
      .rdata     (rdata),
      .fault     (fault),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_be    (bus_be),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // k = number of REQ cycles before the acked one (large k = never ack).
   task automatic run_access(
      input string tag, input logic rd, input logic wr, input logic [2:0] t,
      input logic [31:0] a, input logic [31:0] wd, input int k, input logic [31:0] brd,
      input logic exp_we, input logic [31:0] exp_addr, input logic [3:0] exp_be,
      input logic [31:0] exp_wd, input logic [31:0] exp_rdata, input logic exp_fault,
      input int exp_stall, input int exp_req);
      int  stall_cnt;
      int  req_cnt;
      logic done;
      stall_cnt = 0;
      req_cnt   = 0;
      done      = 1'b0;
      @(negedge clk);
      mem_read  = rd;
      mem_write = wr;
      dm_type   = t;
      addr      = a;
      wdata     = wd;
      bus_rdata = brd;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         if (!stall) begin
            done      = 1'b1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            bus_ack   = 1'b0;
            check({tag, ".rdata"}, rdata, exp_rdata);
            check({tag, ".fault"}, {31'b0, fault}, {31'b0, exp_fault});
         end else begin
            stall_cnt++;
            if (bus_req) begin
               req_cnt++;
               if (req_cnt == 1) begin
                  check({tag, ".bus_we"}, {31'b0, bus_we}, {31'b0, exp_we});
                  check({tag, ".bus_addr"}, bus_addr, exp_addr);
                  check({tag, ".bus_be"}, {28'b0, bus_be}, {28'b0, exp_be});
                  if (exp_we) check({tag, ".bus_wdata"}, bus_wdata, exp_wd);
               end
            end
            bus_ack = bus_req && (req_cnt == k + 1);
            @(negedge clk);
         end
      end
      if (!done) check({tag, ".done_bound"}, 32'd0, 32'd1);
      check({tag, ".stall_cycles"}, stall_cnt, exp_stall);
      check({tag, ".req_cycles"}, req_cnt, exp_req);
      @(negedge clk);
      #1;
      check({tag, ".fault_after"}, {31'b0, fault}, 32'd0);
      check({tag, ".idle_stall"}, {31'b0, stall}, 32'd0);
      $display("vector %s done: rdata=%h fault=%0d stall=%0d req=%0d", tag, rdata, fault, stall_cnt, req_cnt);
   endtask

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; dm_type = 3'b000;
      addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset.stall", {31'b0, stall}, 32'd0);
      check("reset.bus_req", {31'b0, bus_req}, 32'd0);
      check("reset.rdata", rdata, 32'h0);
      check("reset.fault", {31'b0, fault}, 32'd0);
      check("reset.bus_addr", bus_addr, 32'h0);
      check("reset.bus_be", {28'b0, bus_be}, 32'h0);
      $display("vector reset done");

      //          tag    rd wr type    addr          wdata         k  bus_rdata     we  bus_addr      be       bus_wdata     rdata         flt st rq
      run_access("lw",   1, 0, 3'b000, 32'h100, 32'h0,        1, 32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 3, 2);
      run_access("lb",   1, 0, 3'b011, 32'h103, 32'h0,        0, 32'h80FF0000, 0, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 2, 1);
      run_access("lbu",  1, 0, 3'b100, 32'h103, 32'h0,        0, 32'h80FF0000, 0, 32'h100, 4'b1000, 32'h0,        32'h00000080, 0, 2, 1);
      run_access("lhu",  1, 0, 3'b010, 32'h102, 32'h0,        0, 32'h80FF0000, 0, 32'h100, 4'b1100, 32'h0,        32'h000080FF, 0, 2, 1);
      run_access("lh",   1, 0, 3'b001, 32'h200, 32'h0,        2, 32'h00008001, 0, 32'h200, 4'b0011, 32'h0,        32'hFFFF8001, 0, 4, 3);
      run_access("sh",   0, 1, 3'b001, 32'h102, 32'h1234ABCD, 2, 32'h11111111, 1, 32'h100, 4'b1100, 32'hABCDABCD, 32'h0,        0, 4, 3);
      run_access("sb",   0, 1, 3'b011, 32'h101, 32'h0000005A, 0, 32'h22222222, 1, 32'h100, 4'b0010, 32'h5A5A5A5A, 32'h0,        0, 2, 1);
      run_access("sw",   0, 1, 3'b000, 32'h104, 32'hCAFEF00D, 0, 32'h0,        1, 32'h104, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 2, 1);
      run_access("rdwr", 1, 1, 3'b000, 32'h300, 32'h87654321, 0, 32'h33333333, 1, 32'h300, 4'b1111, 32'h87654321, 32'h0,        0, 2, 1);
      run_access("lw7",  1, 0, 3'b111, 32'h108, 32'h0,        0, 32'h0BADF00D, 0, 32'h108, 4'b1111, 32'h0,        32'h0BADF00D, 0, 2, 1);
`ifdef DM_MISALIGN_TRAP_EN
      run_access("lwmis",1, 0, 3'b000, 32'h101, 32'h0,        0, 32'h13579BDF, 0, 32'h100, 4'b1111, 32'h0,        32'h0,        1, 1, 0);
      run_access("lhmis",1, 0, 3'b001, 32'h103, 32'h0,        0, 32'h13579BDF, 0, 32'h100, 4'b1100, 32'h0,        32'h0,        1, 1, 0);
`else
      run_access("lwmis",1, 0, 3'b000, 32'h101, 32'h0,        0, 32'h13579BDF, 0, 32'h100, 4'b1111, 32'h0,        32'h13579BDF, 0, 2, 1);
      run_access("lhmis",1, 0, 3'b001, 32'h103, 32'h0,        0, 32'h13579BDF, 0, 32'h100, 4'b1100, 32'h0,        32'h00001357, 0, 2, 1);
`endif
      run_access("tmo",  1, 0, 3'b000, 32'h400, 32'h0,       99, 32'hFFFFFFFF, 0, 32'h400, 4'b1111, 32'h0,        32'h0,        1, 5, 4);
      run_access("pre",  1, 0, 3'b000, 32'h500, 32'h0,        0, 32'hA5A5A5A5, 0, 32'h500, 4'b1111, 32'h0,        32'hA5A5A5A5, 0, 2, 1);

      // Reset during REQ, then a late ack.
      @(negedge clk);
      mem_read = 1'b1; dm_type = 3'b000; addr = 32'h600; bus_rdata = 32'h5555AAAA;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rstreq.in_req", {31'b0, bus_req}, 32'd1);
      rst = 1'b1;
      mem_read = 1'b0;
      @(negedge clk);
      #1;
      check("rstreq.bus_req", {31'b0, bus_req}, 32'd0);
      check("rstreq.stall", {31'b0, stall}, 32'd0);
      rst = 1'b0;
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      check("rstreq.rdata", rdata, 32'h0);
      check("rstreq.fault", {31'b0, fault}, 32'd0);
      check("rstreq.bus_req2", {31'b0, bus_req}, 32'd0);
      @(negedge clk);
      #1;
      check("rstreq.rdata2", rdata, 32'h0);
      check("rstreq.stall2", {31'b0, stall}, 32'd0);
      $display("vector rst_mid_req done: rdata=%h fault=%0d", rdata, fault);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
